// File: rtl/reg_write_arbiter_if.sv
// Bus bundle between four register-write requesters and reg_write_arbiter.
// master = requester side, slave = arbiter side.
interface reg_write_arbiter_if #(
  parameter int DW = 8
);
  logic [3:0]    req;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic [DW-1:0] wdata2;
  logic [DW-1:0] wdata3;
  logic [3:0]    gnt;
  logic [3:0]    ack;
  logic          load_out;
  logic [DW-1:0] data_out;
  logic [1:0]    owner;
  logic [7:0]    wr_count;
  logic          busy;

  modport master (
    output req, wdata0, wdata1, wdata2, wdata3,
    input  gnt, ack, load_out, data_out, owner, wr_count, busy
  );

  modport slave (
    input  req, wdata0, wdata1, wdata2, wdata3,
    output gnt, ack, load_out, data_out, owner, wr_count, busy
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Four-requester arbiter feeding one shared register: IDLE -> LOAD -> DONE per write.
// Round-robin by default; define ARB_FIXED_PRIO_EN for lowest-index-wins priority.
module reg_write_arbiter #(
  parameter int DW = 8
) (
  input  logic                Clk,
  input  logic                reset,
  reg_write_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [3:0]    ack_q, ack_d;
  logic          load_q, load_d;
  logic [DW-1:0] data_q, data_d;
  logic [1:0]    owner_q, owner_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          busy_q, busy_d;
`ifndef ARB_FIXED_PRIO_EN
  logic [1:0]    last_q, last_d;
`endif

  logic [DW-1:0] wdata [4];
  logic [1:0]    win;
  logic [1:0]    cand;
  logic          found;

  always_comb begin
    wdata[0] = bus.wdata0;
    wdata[1] = bus.wdata1;
    wdata[2] = bus.wdata2;
    wdata[3] = bus.wdata3;
  end

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      cand = i[1:0];
      if (!found && bus.req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end
`else
  // Search starts one past the last winner; 2-bit add wraps mod 4.
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = last_q + k[1:0];
      if (!found && bus.req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ack_d   = ack_q;
    load_d  = load_q;
    data_d  = data_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
`ifndef ARB_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        ack_d = '0;
        if (bus.req != '0) begin
          state_d = LOAD;
          gnt_d   = 4'b0001 << win;
          load_d  = 1'b1;
          data_d  = wdata[win];
          owner_d = win;
`ifndef ARB_FIXED_PRIO_EN
          last_d  = win;
`endif
        end else begin
          gnt_d  = '0;
          load_d = 1'b0;
        end
      end
      LOAD: begin
        state_d = DONE;
        gnt_d   = '0;
        load_d  = 1'b0;
        ack_d   = 4'b0001 << owner_q;
        cnt_d   = cnt_q + 8'd1;
      end
      DONE: begin
        state_d = IDLE;
        ack_d   = '0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        ack_d   = '0;
        load_d  = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      load_q  <= 1'b0;
      data_q  <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      last_q  <= 2'd3;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      load_q  <= load_d;
      data_q  <= data_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
`ifndef ARB_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.ack      = ack_q;
  assign bus.load_out = load_q;
  assign bus.data_out = data_q;
  assign bus.owner    = owner_q;
  assign bus.wr_count = cnt_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: vector table, corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_reg_write_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  reg_write_arbiter_if #(.DW(8)) bus ();

  reg_write_arbiter #(.DW(8)) dut (
    .Clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] req;
    logic [7:0] wd;
    logic [3:0] e_gnt;
    logic [3:0] e_ack;
    logic       e_load;
    logic [7:0] e_data;
    logic [1:0] e_owner;
    logic [7:0] e_cnt;
    logic       e_busy;
  } vec_t;

  vec_t tv [13];

  // Reference model: pending-write countdown, winner picked by policy rule.
  int         m_left;
  logic [1:0] m_last;
  logic [3:0] m_gnt, m_ack;
  logic       m_load;
  logic [7:0] m_data;
  logic [1:0] m_owner;
  int         m_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] r, input logic [7:0] w0, input logic [7:0] w1,
                       input logic [7:0] w2, input logic [7:0] w3);
    bus.req    = r;
    bus.wdata0 = w0;
    bus.wdata1 = w1;
    bus.wdata2 = w2;
    bus.wdata3 = w3;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic int pick(input logic [3:0] r, input int last);
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= 4; k++) if (r[(last + k) % 4]) return (last + k) % 4;
`endif
    return 0;
  endfunction

  task automatic m_reset();
    m_left = 0; m_last = 2'd3; m_gnt = '0; m_ack = '0; m_load = 1'b0;
    m_data = '0; m_owner = '0; m_count = 0;
  endtask

  task automatic m_step(input logic [3:0] r, input logic [7:0] wd [4]);
    int w;
    if (m_left == 0) begin
      m_ack = '0;
      if (r != 0) begin
        w = pick(r, int'(m_last));
        m_gnt = 4'(1 << w); m_load = 1'b1; m_data = wd[w];
        m_owner = 2'(w); m_last = 2'(w); m_left = 2;
      end else begin
        m_gnt = '0; m_load = 1'b0;
      end
    end else if (m_left == 2) begin
      m_gnt = '0; m_load = 1'b0;
      m_ack = 4'(1 << m_owner);
      m_count = (m_count + 1) % 256;
      m_left = 1;
    end else begin
      m_ack = '0;
      m_left = 0;
    end
  endtask

  task automatic write_one(input logic [7:0] d);
    int waited;
    drive(4'b0001, d, 8'h00, 8'h00, 8'h00);
    waited = 0;
    while (bus.ack == 4'b0000 && waited < 6) begin
      tick();
      waited++;
    end
    if (bus.ack == 4'b0000) chk("wrap_ack_timeout", 32'd0, 32'd1);
    bus.req = 4'b0000;
    tick();
  endtask

  initial begin
    logic [7:0]  seen [$];
    int          load_cyc [$];
    logic [3:0]  r, pend;
    logic [7:0]  wd [4];
    logic [27:0] act, exp;
    int          wa, wb;

    checks = 0;
    failures = 0;
    rst_n = 1'b1;
    drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);

    // Asynchronous reset: outputs clear before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_load", 32'(bus.load_out), 32'd0);
    chk("rst_data", 32'(bus.data_out), 32'd0);
    chk("rst_owner", 32'(bus.owner), 32'd0);
    chk("rst_count", 32'(bus.wr_count), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    tick();
    rst_n = 1'b1;

    // Reset during LOAD discards the write.
    drive(4'b0001, 8'h5A, 8'h00, 8'h00, 8'h00);
    tick();
    chk("midload_entered", 32'(bus.load_out), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midload_gnt", 32'(bus.gnt), 32'd0);
    chk("midload_load", 32'(bus.load_out), 32'd0);
    chk("midload_busy", 32'(bus.busy), 32'd0);
    bus.req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("midload_ack", 32'(bus.ack), 32'd0);
    chk("midload_count", 32'(bus.wr_count), 32'd0);

    // Vector table, applied after a fresh reset.
`ifdef ARB_FIXED_PRIO_EN
    wa = 1; wb = 3;
`else
    wa = 3; wb = 1;
`endif
    tv[0]  = '{4'b0001, 8'hD3, 4'b0001, 4'b0000, 1'b1, 8'hD3, 2'd0, 8'd0, 1'b1};
    tv[1]  = '{4'b0001, 8'hD3, 4'b0000, 4'b0001, 1'b0, 8'hD3, 2'd0, 8'd1, 1'b1};
    tv[2]  = '{4'b0000, 8'hD3, 4'b0000, 4'b0000, 1'b0, 8'hD3, 2'd0, 8'd1, 1'b0};
    tv[3]  = '{4'b0000, 8'h11, 4'b0000, 4'b0000, 1'b0, 8'hD3, 2'd0, 8'd1, 1'b0};
    tv[4]  = '{4'b0100, 8'hAA, 4'b0100, 4'b0000, 1'b1, 8'hAA, 2'd2, 8'd1, 1'b1};
    tv[5]  = '{4'b0000, 8'hFE, 4'b0000, 4'b0100, 1'b0, 8'hAA, 2'd2, 8'd2, 1'b1};
    tv[6]  = '{4'b0000, 8'hFE, 4'b0000, 4'b0000, 1'b0, 8'hAA, 2'd2, 8'd2, 1'b0};
    tv[7]  = '{4'b1010, 8'h5C, 4'(1 << wa), 4'b0000, 1'b1, 8'h5C, 2'(wa), 8'd2, 1'b1};
    tv[8]  = '{4'b1010, 8'h5C, 4'b0000, 4'(1 << wa), 1'b0, 8'h5C, 2'(wa), 8'd3, 1'b1};
    tv[9]  = '{4'(1 << wb), 8'h5C, 4'b0000, 4'b0000, 1'b0, 8'h5C, 2'(wa), 8'd3, 1'b0};
    tv[10] = '{4'(1 << wb), 8'h77, 4'(1 << wb), 4'b0000, 1'b1, 8'h77, 2'(wb), 8'd3, 1'b1};
    tv[11] = '{4'(1 << wb), 8'h77, 4'b0000, 4'(1 << wb), 1'b0, 8'h77, 2'(wb), 8'd4, 1'b1};
    tv[12] = '{4'b0000, 8'h77, 4'b0000, 4'b0000, 1'b0, 8'h77, 2'(wb), 8'd4, 1'b0};

    do_reset();
    foreach (tv[i]) begin
      drive(tv[i].req, tv[i].wd, tv[i].wd, tv[i].wd, tv[i].wd);
      tick();
      chk($sformatf("vec%0d_gnt", i), 32'(bus.gnt), 32'(tv[i].e_gnt));
      chk($sformatf("vec%0d_ack", i), 32'(bus.ack), 32'(tv[i].e_ack));
      chk($sformatf("vec%0d_load", i), 32'(bus.load_out), 32'(tv[i].e_load));
      chk($sformatf("vec%0d_data", i), 32'(bus.data_out), 32'(tv[i].e_data));
      chk($sformatf("vec%0d_owner", i), 32'(bus.owner), 32'(tv[i].e_owner));
      chk($sformatf("vec%0d_count", i), 32'(bus.wr_count), 32'(tv[i].e_cnt));
      chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(tv[i].e_busy));
    end

    // All four requesting continuously for 12 cycles.
    do_reset();
    drive(4'b1111, 8'hA0, 8'hA1, 8'hA2, 8'hA3);
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (bus.load_out) begin
        seen.push_back(bus.data_out);
        load_cyc.push_back(c);
      end
    end
    bus.req = 4'b0000;
    chk("all_loads", 32'(seen.size()), 32'd4);
    for (int k = 0; k < seen.size() && k < 4; k++) begin
`ifdef ARB_FIXED_PRIO_EN
      chk($sformatf("all_data%0d", k), 32'(seen[k]), 32'hA0);
`else
      chk($sformatf("all_data%0d", k), 32'(seen[k]), 32'hA0 + 32'(k));
`endif
      if (k > 0) chk($sformatf("all_gap%0d", k), 32'(load_cyc[k] - load_cyc[k-1]), 32'd3);
    end
    chk("all_count", 32'(bus.wr_count), 32'd4);
    tick();
    tick();

    // 256 single writes: counter wraps to zero.
    do_reset();
    for (int n = 1; n <= 256; n++) begin
      write_one(8'(n));
      if (n == 255) chk("wrap_255", 32'(bus.wr_count), 32'd255);
    end
    chk("wrap_0", 32'(bus.wr_count), 32'd0);

    // Random traffic against the reference model.
    do_reset();
    m_reset();
    pend = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (pend[i] && m_ack[i]) pend[i] = 1'b0;
        else if (pend[i] && m_gnt[i] && ($urandom % 4 == 0)) pend[i] = 1'b0;
        else if (!pend[i] && ($urandom % 3 == 0)) pend[i] = 1'b1;
        wd[i] = 8'($urandom);
      end
      r = pend;
      drive(r, wd[0], wd[1], wd[2], wd[3]);
      m_step(r, wd);
      tick();
      act = {bus.gnt, bus.ack, bus.load_out, bus.data_out, bus.owner, bus.wr_count, bus.busy};
      exp = {m_gnt, m_ack, m_load, m_data, m_owner, 8'(m_count), (m_left != 0)};
      chk($sformatf("rand_cyc%0d", cyc), 32'(act), 32'(exp));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
